remove_cp: RTL and testbench
============================

Name: remove_cp

Overview:
- Receive-side cyclic-prefix removal. Mirror of the transmit CP-insertion stage.
- Input: a continuous complex sample stream from the timing/synchronisation stage. The stream is made of OFDM symbols of LCP+NFFT samples each, with a symbol-start marker.
- Discards the first LCP samples of every symbol and forwards the NFFT useful samples to the FFT.
- Output carries SOP/EOP framing and valid/ready backpressure. Single clock domain.

Parameters:
- DW, 16, sample component width (real and imaginary each).
- LCP, 16, cyclic-prefix length in samples; 0 is legal.
- NFFT, 48, useful-symbol length in samples; must be ≥ 2.
- CW, 16, width of the symbol counter output.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  asynchronous, active-high reset.
- DAT_I_r  in  DW  input sample, real part.
- DAT_I_i  in  DW  input sample, imaginary part.
- VLD_I  in  1  input sample valid.
- SOF_I  in  1  qualified by VLD_I; this beat is sample 0 (first CP sample) of a symbol.
- RDY_O  out  1  ready to accept an input beat.
- DAT_O_r  out  DW  output sample, real part.
- DAT_O_i  out  DW  output sample, imaginary part.
- VLD_O  out  1  output valid.
- SOP_O  out  1  first useful sample of a symbol.
- EOP_O  out  1  last (NFFT-th) useful sample of a symbol.
- RDY_I  in  1  downstream ready.
- SYM_CNT_O  out  CW  count of complete symbols delivered.
- ALIGN_ERR_O  out  1  one-cycle pulse on a misaligned SOF_I.

Behaviour:
- Reset (RST_I=1, asynchronous): state=IDLE, position counter=0, skid buffer emptied.
  - DAT_O_r=0, DAT_O_i=0, VLD_O=0, SOP_O=0, EOP_O=0, SYM_CNT_O=0, ALIGN_ERR_O=0.
  - RDY_O=0 while reset is asserted; RDY_O=1 from the first clock after release.
- Input beat is accepted when VLD_I & RDY_O. Output beat is taken when VLD_O & RDY_I.
- Position counter: width $clog2(LCP+NFFT). Counts accepted beats within a symbol and wraps at LCP+NFFT-1 to 0.
- FSM:
  - IDLE: RDY_O=1. Accepted beats without SOF_I are dropped.
    - Accepted beat with SOF_I: pos←1; go to DROP (LCP>1), PASS (LCP=1), or forward it as useful sample 0 (LCP=0).
  - DROP: RDY_O=1 and accepted beats are discarded.
    - When the beat at pos=LCP-1 is accepted, go to PASS.
  - PASS: RDY_O = skid buffer not full. Each accepted beat is written to the skid buffer with SOP=(pos==LCP) and EOP=(pos==LCP+NFFT-1).
    - On EOP acceptance: pos←0 and go to DROP (LCP>0, free-running into the next symbol) or stay in PASS (LCP=0).
- Next-symbol start: SOF_I is not required on subsequent symbols. If SOF_I arrives at pos=0, it is consistent and has no effect.
- Misalignment: SOF_I on an accepted beat with pos≠0, in DROP or PASS:
  - ALIGN_ERR_O=1 for the following cycle.
  - The beat is treated as sample 0 of a new symbol (pos←1, go to DROP).
  - The partially forwarded symbol is truncated: no EOP is emitted for it, and SYM_CNT_O is not incremented.
- Output path: 2-entry skid buffer. Latency is 1 cycle from input acceptance to VLD_O with no stall.
  - Full throughput of 1 sample/clock while RDY_I=1.
  - Output data, SOP and EOP are held stable while VLD_O=1 and RDY_I=0.
  - Buffer full: RDY_O=0 in PASS only; DROP and IDLE never stall.
  - Simultaneous push and pop with one entry: occupancy unchanged, no bubble.
- SYM_CNT_O: increments by 1 when an EOP beat is taken at the output; wraps modulo 2^CW.
- Reset mid-symbol: all buffered samples are lost and the FSM returns to IDLE; SOF_I is needed to resume.
- No arithmetic is performed on samples; they pass bit-exact.

Decomposition:
- Shared package ofdm_pkg holds:
  - the LCP, NFFT and DW defaults, shared with the TX CP-insertion stage;
  - the FSM state encoding (IDLE, DROP, PASS);
  - the symbol length constant LCP+NFFT.
- Sub-module rcp_skid_buf: generic 2-entry valid/ready buffer carrying {SOP, EOP, DAT_r, DAT_i}.

Test Plan:
1. Reset, then 3 back-to-back symbols with samples r=i=sample index 0..63, SOF_I only on the first beat, RDY_I=1 → 144 output beats with values 16..63 per symbol; SOP_O on 16 and EOP_O on 63; SYM_CNT_O=3; no ALIGN_ERR_O.
2. Same stimulus with RDY_I toggling 1,0,0,1,... → identical output sequence, no loss or duplication, data stable during stalls, RDY_O=0 only while in PASS with the buffer full.
3. SOF_I asserted again at pos=30 of symbol 1 → ALIGN_ERR_O pulses once; symbol 1 output stops after 14 samples with no EOP; new symbol samples 16..63 follow with SOP/EOP; SYM_CNT_O=1.
4. LCP=0, NFFT=48 build, 2 symbols → all 96 beats forwarded; SOP_O at pos 0, EOP_O at pos 47.
5. Assert RST_I for 1 cycle mid-PASS at pos=40 → outputs return to reset values at once; beats without SOF_I after release are dropped; the next SOF_I restarts cleanly.
6. Beats with VLD_I=0 interleaved (50% duty) → pos advances only on accepted beats; output content is identical to scenario 1.

Source files
------------

// File: rtl/ofdm_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_pkg
// Shared OFDM framing constants used by the TX CP-insertion and RX CP-removal
// stages, plus the CP-removal FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package ofdm_pkg;

   localparam int unsigned DW_DEF      = 16;
   localparam int unsigned LCP_DEF     = 16;
   localparam int unsigned NFFT_DEF    = 48;
   localparam int unsigned CW_DEF      = 16;
   localparam int unsigned SYM_LEN_DEF = LCP_DEF + NFFT_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DROP = 2'd1,
      PASS = 2'd2
   } rcp_state_e;

   // Full symbol length (prefix + useful part) in samples.
   function automatic int unsigned sym_len(input int unsigned lcp, input int unsigned nfft);
      return lcp + nfft;
   endfunction

endpackage

// File: rtl/rcp_skid_buf.sv
// ---------------------------------------------------------------------------
// rcp_skid_buf
// Generic 2-entry valid/ready buffer with a registered head entry.
// Ports:
//   CLK_I, RST_I         clock, asynchronous active-high reset
//   up_vld/up_rdy/up_dat upstream beat; accepted when up_vld & up_rdy
//   dn_vld/dn_rdy/dn_dat downstream beat; taken when dn_vld & dn_rdy
// ---------------------------------------------------------------------------
module rcp_skid_buf #(
   parameter int unsigned W = 34
) (
   input  logic         CLK_I,
   input  logic         RST_I,
   input  logic         up_vld,
   output logic         up_rdy,
   input  logic [W-1:0] up_dat,
   output logic         dn_vld,
   input  logic         dn_rdy,
   output logic [W-1:0] dn_dat
);

   logic [W-1:0] mem0_q, mem1_q;
   logic         v0_q, v1_q;
   logic         push, pop;

   assign push   = up_vld && !v1_q;
   assign pop    = v0_q && dn_rdy;
   assign up_rdy = !v1_q;
   assign dn_vld = v0_q;
   assign dn_dat = mem0_q;

   // Entry 0 always drives the output; entry 1 only fills while entry 0 stalls.
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         mem0_q <= '0;
         mem1_q <= '0;
         v0_q   <= 1'b0;
         v1_q   <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (!v0_q) begin
                  mem0_q <= up_dat;
                  v0_q   <= 1'b1;
               end else begin
                  mem1_q <= up_dat;
                  v1_q   <= 1'b1;
               end
            end
            2'b01: begin
               mem0_q <= mem1_q;
               v0_q   <= v1_q;
               v1_q   <= 1'b0;
            end
            // push implies entry 1 empty, so a single-entry pass-through
            2'b11:   mem0_q <= up_dat;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/remove_cp.sv
// ---------------------------------------------------------------------------
// remove_cp
// Receive-side cyclic-prefix removal: drops the first LCP samples of every
// LCP+NFFT symbol and forwards the NFFT useful samples with SOP/EOP framing.
// Ports:
//   CLK_I, RST_I              clock, asynchronous active-high reset
//   DAT_I_r/DAT_I_i/VLD_I     input complex sample and valid
//   SOF_I                     symbol-start marker (first CP sample)
//   RDY_O                     input ready
//   DAT_O_r/DAT_O_i/VLD_O     output complex sample and valid
//   SOP_O/EOP_O               first / last useful sample of a symbol
//   RDY_I                     downstream ready
//   SYM_CNT_O                 complete symbols delivered (wraps)
//   ALIGN_ERR_O               one-cycle pulse on a misaligned SOF_I
// ---------------------------------------------------------------------------
module remove_cp
   import ofdm_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned LCP  = LCP_DEF,
   parameter int unsigned NFFT = NFFT_DEF,
   parameter int unsigned CW   = CW_DEF
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I_r,
   input  logic [DW-1:0] DAT_I_i,
   input  logic          VLD_I,
   input  logic          SOF_I,
   output logic          RDY_O,
   output logic [DW-1:0] DAT_O_r,
   output logic [DW-1:0] DAT_O_i,
   output logic          VLD_O,
   output logic          SOP_O,
   output logic          EOP_O,
   input  logic          RDY_I,
   output logic [CW-1:0] SYM_CNT_O,
   output logic          ALIGN_ERR_O
);

   localparam int unsigned SLEN = sym_len(LCP, NFFT);
   localparam int unsigned PW   = $clog2(SLEN);
   localparam int unsigned BW   = 2 * DW + 2;

   localparam logic [PW-1:0] POS_LAST      = PW'(SLEN - 1);
   localparam logic [PW-1:0] POS_CP        = PW'(LCP);
   localparam logic [PW-1:0] POS_DROP_LAST = PW'((LCP > 0) ? (LCP - 1) : 0);

   // Sample 0 is consumed on entry, so a 1-sample prefix goes straight to PASS.
   localparam rcp_state_e START_ST = (LCP > 1) ? DROP : PASS;
   localparam rcp_state_e EOP_ST   = (LCP > 0) ? DROP : PASS;

   rcp_state_e    state_q, state_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          rdy_en_q;
   logic          align_q;
   logic [CW-1:0] cnt_q;

   logic          buf_rdy;
   logic          rdy_c, acc_c, mis_c, start_c;
   logic          push_c, push_sop_c, push_eop_c;
   logic [BW-1:0] dn_dat;

   // State and position register
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q <= IDLE;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
      end
   end

   // Next state / position
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      if (start_c) begin
         state_d = START_ST;
         pos_d   = PW'(1);
      end else if (acc_c) begin
         case (state_q)
            DROP: begin
               pos_d = pos_q + PW'(1);
               if (pos_q == POS_DROP_LAST) state_d = PASS;
            end
            PASS: begin
               if (pos_q == POS_LAST) begin
                  pos_d   = '0;
                  state_d = EOP_ST;
               end else begin
                  pos_d = pos_q + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake, alignment detection and buffer write decode
   always_comb begin
      rdy_c      = 1'b0;
      acc_c      = 1'b0;
      mis_c      = 1'b0;
      start_c    = 1'b0;
      push_c     = 1'b0;
      push_sop_c = 1'b0;
      push_eop_c = 1'b0;

      // Only PASS can back-pressure; prefix samples are always swallowed.
      rdy_c   = rdy_en_q && !((state_q == PASS) && !buf_rdy);
      acc_c   = VLD_I && rdy_c;
      mis_c   = acc_c && SOF_I && (state_q != IDLE) && (pos_q != '0);
      start_c = (acc_c && SOF_I && (state_q == IDLE)) || mis_c;

      if (start_c) begin
         push_c     = (LCP == 0);
         push_sop_c = 1'b1;
      end else if (acc_c && (state_q == PASS)) begin
         push_c     = 1'b1;
         push_sop_c = (pos_q == POS_CP);
         push_eop_c = (pos_q == POS_LAST);
      end
   end

   // Ready enable, alignment pulse and delivered-symbol counter
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         rdy_en_q <= 1'b0;
         align_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         rdy_en_q <= 1'b1;
         align_q  <= mis_c;
         if (VLD_O && RDY_I && EOP_O) cnt_q <= cnt_q + CW'(1);
      end
   end

   rcp_skid_buf #(
      .W (BW)
   ) u_skid (
      .CLK_I  (CLK_I),
      .RST_I  (RST_I),
      .up_vld (push_c),
      .up_rdy (buf_rdy),
      .up_dat ({push_sop_c, push_eop_c, DAT_I_r, DAT_I_i}),
      .dn_vld (VLD_O),
      .dn_rdy (RDY_I),
      .dn_dat (dn_dat)
   );

   assign {SOP_O, EOP_O, DAT_O_r, DAT_O_i} = dn_dat;
   assign RDY_O       = rdy_c;
   assign SYM_CNT_O   = cnt_q;
   assign ALIGN_ERR_O = align_q;

endmodule

// File: tb/tb_remove_cp.sv
// ---------------------------------------------------------------------------
// tb_remove_cp
// Scoreboard bench for remove_cp: dut_a uses the default 16/48 framing,
// dut_b uses a zero-length prefix (LCP=0, NFFT=48).
// ---------------------------------------------------------------------------
module tb_remove_cp;

   localparam int unsigned DW     = 16;
   localparam int unsigned CW     = 16;
   localparam int unsigned BUDGET = 400;

   typedef struct packed {
      logic          sop;
      logic          eop;
      logic [DW-1:0] r;
      logic [DW-1:0] i;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] dat_r = '0, dat_i = '0;
   logic          vld_a = 1'b0, sof_a = 1'b0, vld_b = 1'b0, sof_b = 1'b0;
   logic          rdy_i = 1'b1;

   logic          rdy_a, vo_a, sop_a, eop_a, aerr_a;
   logic [DW-1:0] dor_a, doi_a;
   logic [CW-1:0] cnt_a;
   logic          rdy_b, vo_b, sop_b, eop_b, aerr_b;
   logic [DW-1:0] dor_b, doi_b;
   logic [CW-1:0] cnt_b;

   int   checks   = 0;
   int   failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   bit   armed    = 1'b0;
   bit   tog_en   = 1'b0;
   int   ph       = 0;
   int   align_a  = 0;
   int   rdylow_a = 0;

   always #5 clk = ~clk;

   remove_cp dut_a (
      .CLK_I(clk), .RST_I(rst), .DAT_I_r(dat_r), .DAT_I_i(dat_i),
      .VLD_I(vld_a), .SOF_I(sof_a), .RDY_O(rdy_a),
      .DAT_O_r(dor_a), .DAT_O_i(doi_a), .VLD_O(vo_a), .SOP_O(sop_a), .EOP_O(eop_a),
      .RDY_I(rdy_i), .SYM_CNT_O(cnt_a), .ALIGN_ERR_O(aerr_a)
   );

   remove_cp #(.LCP(0), .NFFT(48)) dut_b (
      .CLK_I(clk), .RST_I(rst), .DAT_I_r(dat_r), .DAT_I_i(dat_i),
      .VLD_I(vld_b), .SOF_I(sof_b), .RDY_O(rdy_b),
      .DAT_O_r(dor_b), .DAT_O_i(doi_b), .VLD_O(vo_b), .SOP_O(sop_b), .EOP_O(eop_b),
      .RDY_I(rdy_i), .SYM_CNT_O(cnt_b), .ALIGN_ERR_O(aerr_b)
   );

   // Downstream ready: 1,0,0 pattern when enabled, otherwise always ready
   always @(posedge clk) begin
      #1;
      ph    = (ph + 1) % 3;
      rdy_i = tog_en ? (ph == 0) : 1'b1;
   end

   // Output monitor for dut_a: scoreboard pop, stall hold, ready/alignment watch
   exp_t        e_a;
   logic [33:0] last_a;
   bit          stall_a = 1'b0;
   always @(negedge clk) begin
      if (armed && !rst) begin
         if (stall_a) begin
            checks++;
            if (vo_a !== 1'b1 || {sop_a, eop_a, dor_a, doi_a} !== last_a) begin
               failures++;
               $display("FAIL hold_a got vld=%b %h required vld=1 %h", vo_a, {sop_a, eop_a, dor_a, doi_a}, last_a);
            end
         end
         if (rdy_a !== 1'b1) begin
            rdylow_a++;
            checks++;
            if (vo_a !== 1'b1) begin
               failures++;
               $display("FAIL rdy_low_a got RDY_O=0 with VLD_O=%b required VLD_O=1", vo_a);
            end
         end
         if (aerr_a === 1'b1) align_a++;
         if (vo_a === 1'b1 && rdy_i === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
               failures++;
               $display("FAIL extra_out_a got %h required no output", {sop_a, eop_a, dor_a, doi_a});
            end else begin
               e_a = q_a.pop_front();
               if ({sop_a, eop_a, dor_a, doi_a} !== e_a) begin
                  failures++;
                  $display("FAIL out_a got sop=%b eop=%b r=%0d i=%0d required sop=%b eop=%b r=%0d i=%0d",
                           sop_a, eop_a, dor_a, doi_a, e_a.sop, e_a.eop, e_a.r, e_a.i);
               end
            end
         end
         stall_a = (vo_a === 1'b1) && (rdy_i !== 1'b1);
         last_a  = {sop_a, eop_a, dor_a, doi_a};
      end else begin
         stall_a = 1'b0;
      end
   end

   // Output monitor for dut_b (zero-length prefix build)
   exp_t e_b;
   always @(negedge clk) begin
      if (armed && !rst) begin
         if (aerr_b === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL align_b got ALIGN_ERR_O=1 required 0");
         end
         if (vo_b === 1'b1 && rdy_i === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
               failures++;
               $display("FAIL extra_out_b got %h required no output", {sop_b, eop_b, dor_b, doi_b});
            end else begin
               e_b = q_b.pop_front();
               if ({sop_b, eop_b, dor_b, doi_b} !== e_b) begin
                  failures++;
                  $display("FAIL out_b got sop=%b eop=%b r=%0d i=%0d required sop=%b eop=%b r=%0d i=%0d",
                           sop_b, eop_b, dor_b, doi_b, e_b.sop, e_b.eop, e_b.r, e_b.i);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Drive one beat, wait (bounded) for acceptance, record expected output.
   task automatic drive_beat(input bit sel, input logic [DW-1:0] r, input logic [DW-1:0] i,
                             input bit sof, input bit fwd, input bit sop, input bit eop,
                             input bit nostall);
      int   w;
      exp_t e;
      dat_r = r;
      dat_i = i;
      if (sel) begin vld_b = 1'b1; sof_b = sof; end
      else     begin vld_a = 1'b1; sof_a = sof; end
      w = 0;
      while ((sel ? rdy_b : rdy_a) !== 1'b1 && w < BUDGET) begin
         @(negedge clk);
         w++;
      end
      if (w >= BUDGET) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout got RDY_O=0 for %0d cycles required acceptance", w);
      end else begin
         if (nostall) begin
            checks++;
            if (w != 0) begin
               failures++;
               $display("FAIL no_stall got %0d wait cycles required 0 (r=%0d)", w, r);
            end
         end
         if (fwd) begin
            e = {sop, eop, r, i};
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
         end
      end
      @(negedge clk);
      vld_a = 1'b0; sof_a = 1'b0;
      vld_b = 1'b0; sof_b = 1'b0;
   endtask

   // Drive symbol samples k0..k1-1; r=k, i=k+256*sid; useful part is k>=lcp.
   task automatic drive_symbol(input bit sel, input int sid, input int lcp, input int nfft,
                               input int k0, input int k1, input bit sof0, input bit gap);
      for (int k = k0; k < k1; k++) begin
         drive_beat(sel, DW'(k), DW'(k + sid * 256), sof0 && (k == k0),
                    k >= lcp, k == lcp, k == lcp + nfft - 1, k < lcp);
         if (gap) @(negedge clk);
      end
   endtask

   task automatic wait_drain(input bit sel);
      int w;
      w = 0;
      while ((sel ? q_b.size() : q_a.size()) != 0 && w < BUDGET * 4) begin
         @(negedge clk);
         w++;
      end
      if (w >= BUDGET * 4) begin
         checks++;
         failures++;
         $display("FAIL drain got %0d pending required 0", sel ? q_b.size() : q_a.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      armed  = 1'b0;
      tog_en = 1'b0;
      vld_a  = 1'b0; sof_a = 1'b0;
      vld_b  = 1'b0; sof_b = 1'b0;
      rst    = 1'b1;
      repeat (2) @(negedge clk);
      q_a.delete();
      q_b.delete();
      align_a  = 0;
      rdylow_a = 0;
      rst      = 1'b0;
      repeat (2) @(negedge clk);
      armed = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rdy_a, rdy_b} !== 2'b00) begin
         failures++;
         $display("FAIL reset_rdy got %b%b required 00", rdy_a, rdy_b);
      end
      checks++;
      if ({vo_a, sop_a, eop_a, aerr_a, vo_b, sop_b, eop_b, aerr_b} !== 8'h00) begin
         failures++;
         $display("FAIL reset_flags got %b required 00000000",
                  {vo_a, sop_a, eop_a, aerr_a, vo_b, sop_b, eop_b, aerr_b});
      end
      checks++;
      if ({dor_a, doi_a, cnt_a, dor_b, doi_b, cnt_b} !== '0) begin
         failures++;
         $display("FAIL reset_data got %h %h %h required 0", dor_a, doi_a, cnt_a);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rdy_a !== 1'b0) begin
         failures++;
         $display("FAIL rdy_before_clk got %b required 0", rdy_a);
      end
      @(negedge clk);
      checks++;
      if ({rdy_a, rdy_b} !== 2'b11) begin
         failures++;
         $display("FAIL rdy_after_release got %b%b required 11", rdy_a, rdy_b);
      end
      armed = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      for (int s = 0; s < 3; s++) drive_symbol(1'b0, s, 16, 48, 0, 64, s == 0, 1'b0);
      wait_drain(1'b0);
      checks++;
      if (cnt_a !== 16'd3) begin
         failures++;
         $display("FAIL basic_symcnt got %0d required 3", cnt_a);
      end
      checks++;
      if (align_a != 0) begin
         failures++;
         $display("FAIL basic_align got %0d pulses required 0", align_a);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      tog_en = 1'b1;
      for (int s = 0; s < 3; s++) drive_symbol(1'b0, s, 16, 48, 0, 64, s == 0, 1'b0);
      wait_drain(1'b0);
      tog_en = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cnt_a !== 16'd3) begin
         failures++;
         $display("FAIL bp_symcnt got %0d required 3", cnt_a);
      end
      checks++;
      if (rdylow_a == 0) begin
         failures++;
         $display("FAIL bp_rdy_low got %0d low cycles required >0", rdylow_a);
      end
   endtask

   task automatic test_misalign();
      do_reset();
      drive_symbol(1'b0, 0, 16, 48, 0, 30, 1'b1, 1'b0);
      drive_beat(1'b0, 16'd0, 16'd256, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (aerr_a !== 1'b1) begin
         failures++;
         $display("FAIL align_pulse got %b required 1", aerr_a);
      end
      drive_symbol(1'b0, 1, 16, 48, 1, 2, 1'b0, 1'b0);
      checks++;
      if (aerr_a !== 1'b0) begin
         failures++;
         $display("FAIL align_one_cycle got %b required 0", aerr_a);
      end
      drive_symbol(1'b0, 1, 16, 48, 2, 64, 1'b0, 1'b0);
      wait_drain(1'b0);
      checks++;
      if (cnt_a !== 16'd1) begin
         failures++;
         $display("FAIL misalign_symcnt got %0d required 1", cnt_a);
      end
      checks++;
      if (align_a != 1) begin
         failures++;
         $display("FAIL misalign_pulses got %0d required 1", align_a);
      end
   endtask

   task automatic test_lcp0();
      do_reset();
      for (int s = 0; s < 2; s++) drive_symbol(1'b1, s, 0, 48, 0, 48, s == 0, 1'b0);
      wait_drain(1'b1);
      checks++;
      if (cnt_b !== 16'd2) begin
         failures++;
         $display("FAIL lcp0_symcnt got %0d required 2", cnt_b);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_symbol(1'b0, 0, 16, 48, 0, 64, 1'b1, 1'b0);
      drive_symbol(1'b0, 1, 16, 48, 0, 40, 1'b0, 1'b0);
      checks++;
      if (cnt_a !== 16'd1) begin
         failures++;
         $display("FAIL pre_reset_symcnt got %0d required 1", cnt_a);
      end
      #2;
      armed = 1'b0;
      rst   = 1'b1;
      #1;
      checks++;
      if ({rdy_a, vo_a, sop_a, eop_a, aerr_a} !== 5'b0) begin
         failures++;
         $display("FAIL midrst_flags got %b required 00000", {rdy_a, vo_a, sop_a, eop_a, aerr_a});
      end
      checks++;
      if ({dor_a, doi_a, cnt_a} !== '0) begin
         failures++;
         $display("FAIL midrst_data got r=%0d i=%0d cnt=%0d required 0", dor_a, doi_a, cnt_a);
      end
      q_a.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      armed = 1'b1;
      // Mid-symbol samples without SOF must all be swallowed in IDLE
      for (int k = 20; k < 40; k++)
         drive_beat(1'b0, DW'(k), DW'(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive_symbol(1'b0, 3, 16, 48, 0, 64, 1'b1, 1'b0);
      wait_drain(1'b0);
      checks++;
      if (cnt_a !== 16'd1) begin
         failures++;
         $display("FAIL post_reset_symcnt got %0d required 1", cnt_a);
      end
   endtask

   task automatic test_gaps();
      do_reset();
      for (int s = 0; s < 3; s++) drive_symbol(1'b0, s, 16, 48, 0, 64, s == 0, 1'b1);
      wait_drain(1'b0);
      checks++;
      if (cnt_a !== 16'd3) begin
         failures++;
         $display("FAIL gaps_symcnt got %0d required 3", cnt_a);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_misalign();
      test_lcp0();
      test_reset_mid();
      test_gaps();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
